serv_rf_dbg_arb: RTL and testbench

SERV_RF_DBG_ARB -- requirements
Module: serv_rf_dbg_arb

---
 rtl/serv_rf_dbg_arb_if.sv | 34 +++
 rtl/serv_rf_dbg_arb.sv | 161 ++++++++++++++++
 tb/tb_serv_rf_dbg_arb.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_rf_dbg_arb_if.sv
// ---------------------------------------------------------------------------
// serv_rf_dbg_arb_if
// Debug access channel of the SERV register-file debug arbiter.
//
// The master (the debug requester) issues a single-cycle dbg_req carrying
// dbg_we/dbg_addr/dbg_wdata. The slave (the arbiter) reports dbg_busy while
// the access is in flight, pulses dbg_ack on completion, holds the read
// result on dbg_rdata, and exposes the sticky dropped-request flag dbg_err
// and the worst-case blocking statistic dbg_maxwait.
// ---------------------------------------------------------------------------
interface serv_rf_dbg_arb_if #(
  parameter int width = 8,
  parameter int aw    = 7
);
  logic             dbg_req;
  logic             dbg_we;
  logic [aw-1:0]    dbg_addr;
  logic [width-1:0] dbg_wdata;
  logic             dbg_busy;
  logic             dbg_ack;
  logic [width-1:0] dbg_rdata;
  logic             dbg_err;
  logic [7:0]       dbg_maxwait;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_busy, dbg_ack, dbg_rdata, dbg_err, dbg_maxwait
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_busy, dbg_ack, dbg_rdata, dbg_err, dbg_maxwait
  );
endinterface

// File: rtl/serv_rf_dbg_arb.sv
// ---------------------------------------------------------------------------
// serv_rf_dbg_arb
// Arbitrates a debug port onto the SERV register-file RAM. The core always
// wins: its read/write strobes and addresses pass straight through to the
// RAM in the same cycle. A debug access waits in PEND until the port it
// needs (write or read) is free for one cycle, then steals that cycle.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_core_*              core RAM requests (pass-through, highest priority)
//   o_core_rdata          RAM read data back to the core (combinational)
//   dbg                   debug channel (serv_rf_dbg_arb_if.slave)
//   o_waddr/o_wdata/o_wen RAM write port
//   o_raddr/o_ren         RAM read port
//   i_rdata               RAM read data, valid the cycle after o_ren
// ---------------------------------------------------------------------------
module serv_rf_dbg_arb #(
  parameter int width = 8,
  parameter int aw    = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_core_waddr,
  input  logic [width-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic [aw-1:0]    i_core_raddr,
  input  logic             i_core_ren,
  output logic [width-1:0] o_core_rdata,
  serv_rf_dbg_arb_if.slave dbg,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RCAP = 2'd2,
    ACK  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic             we_q,      we_d;
  logic [aw-1:0]    addr_q,    addr_d;
  logic [width-1:0] wdata_q,   wdata_d;
  logic [7:0]       wait_q,    wait_d;
  logic [width-1:0] rdata_q,   rdata_d;
  logic             err_q,     err_d;
  logic [7:0]       maxwait_q, maxwait_d;

  logic dbg_wr_issue;
  logic dbg_rd_issue;
  logic dbg_ack;
  logic busy;
  logic blocked;

  assign busy    = (state_q != IDLE);
  // The port the pending access needs is taken by the core this cycle.
  assign blocked = we_q ? i_core_wen : i_core_ren;

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_d       = wait_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    maxwait_d    = maxwait_q;
    dbg_wr_issue = 1'b0;
    dbg_rd_issue = 1'b0;
    dbg_ack      = 1'b0;

    // A request arriving while busy is dropped but remembered as an error.
    if (busy && dbg.dbg_req) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (dbg.dbg_req) begin
          we_d    = dbg.dbg_we;
          addr_d  = dbg.dbg_addr;
          wdata_d = dbg.dbg_wdata;
          wait_d  = 8'd0;
          err_d   = 1'b0;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!blocked) begin
          dbg_wr_issue = we_q;
          dbg_rd_issue = !we_q;
          state_d      = we_q ? ACK : RCAP;
          if (wait_q > maxwait_q) begin
            maxwait_d = wait_q;
          end
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      RCAP: begin
        rdata_d = i_rdata;
        state_d = ACK;
      end
      ACK: begin
        dbg_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset also masks this cycle's debug RAM access and ack so an
    // interrupted transfer never touches the RAM.
    if (i_rst) begin
      state_d      = IDLE;
      wait_d       = 8'd0;
      rdata_d      = '0;
      err_d        = 1'b0;
      maxwait_d    = 8'd0;
      dbg_wr_issue = 1'b0;
      dbg_rd_issue = 1'b0;
      dbg_ack      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous and already folded into the *_d values above. The latched
  // request fields (we/addr/wdata) are deliberately not reset: they are only
  // observed after a new request has overwritten them.
  always_ff @(posedge i_clk) begin
    state_q   <= state_d;
    we_q      <= we_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    wait_q    <= wait_d;
    rdata_q   <= rdata_d;
    err_q     <= err_d;
    maxwait_q <= maxwait_d;
  end

  // Core pass-through with absolute priority; debug fills idle slots.
  assign o_wen        = i_core_wen | dbg_wr_issue;
  assign o_waddr      = i_core_wen ? i_core_waddr : addr_q;
  assign o_wdata      = i_core_wen ? i_core_wdata : wdata_q;
  assign o_ren        = i_core_ren | dbg_rd_issue;
  assign o_raddr      = i_core_ren ? i_core_raddr : addr_q;
  assign o_core_rdata = i_rdata;

  assign dbg.dbg_busy    = busy;
  assign dbg.dbg_ack     = dbg_ack;
  assign dbg.dbg_rdata   = rdata_q;
  assign dbg.dbg_err     = err_q;
  assign dbg.dbg_maxwait = maxwait_q;

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// ---------------------------------------------------------------------------
// tb_serv_rf_dbg_arb
// Directed bench for serv_rf_dbg_arb. A small RAM answers the DUT's RAM
// port; a transaction-level model predicts every output each cycle, and
// literal expectations pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_serv_rf_dbg_arb;
  localparam int W  = 8;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] core_waddr, core_raddr;
  logic [W-1:0]  core_wdata;
  logic          core_wen, core_ren;
  logic [W-1:0]  core_rdata;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0]  wdata, rdata;
  logic          wen, ren;

  serv_rf_dbg_arb_if #(.width(W), .aw(AW)) dbg_if ();

  serv_rf_dbg_arb #(.width(W), .aw(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_core_waddr (core_waddr),
    .i_core_wdata (core_wdata),
    .i_core_wen   (core_wen),
    .i_core_raddr (core_raddr),
    .i_core_ren   (core_ren),
    .o_core_rdata (core_rdata),
    .dbg          (dbg_if),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_wen        (wen),
    .o_raddr      (raddr),
    .o_ren        (ren),
    .i_rdata      (rdata)
  );

  // ---------------- RAM environment (read-before-write, 1-cycle read) ----
  logic         ram_clr;
  logic [W-1:0] ram [128];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) ram[i] <= '0;
      rdata <= '0;
    end else begin
      if (ren) rdata <= ram[raddr];
      if (wen) ram[waddr] <= wdata;
    end
  end

  // ---------------- bookkeeping ------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ------------------------------
  logic         cmp_en;
  bit           m_busy, m_we, m_issued, m_err;
  logic [AW-1:0] m_addr;
  logic [W-1:0] m_wdata, m_rdata, m_cap;
  int           m_wait, m_maxwait, m_since;
  logic [W-1:0] shadow [128];
  bit           e_issue, e_ack, e_wen, e_ren;

  always @(negedge clk) begin
    if (!cmp_en) begin
      m_busy = 0; m_issued = 0; m_err = 0; m_we = 0;
      m_rdata = '0; m_cap = '0; m_wait = 0; m_maxwait = 0; m_since = 0;
      m_addr = '0; m_wdata = '0;
      for (int i = 0; i < 128; i++) shadow[i] = '0;
    end else begin
      // The debug access goes out on the first cycle its port is free; a
      // write acks one cycle later, a read two cycles later.
      e_issue = m_busy && !m_issued && !rst && (m_we ? !core_wen : !core_ren);
      e_ack   = m_busy && m_issued && !rst && (m_since == (m_we ? 1 : 2));
      e_wen   = core_wen || (e_issue && m_we);
      e_ren   = core_ren || (e_issue && !m_we);

      check("m_wen", 32'(wen), 32'(e_wen));
      check("m_ren", 32'(ren), 32'(e_ren));
      if (e_wen) begin
        check("m_waddr", 32'(waddr), 32'(core_wen ? core_waddr : m_addr));
        check("m_wdata", 32'(wdata), 32'(core_wen ? core_wdata : m_wdata));
      end
      if (e_ren) check("m_raddr", 32'(raddr), 32'(core_ren ? core_raddr : m_addr));
      check("m_core_rdata", 32'(core_rdata), 32'(rdata));
      check("m_busy",    32'(dbg_if.dbg_busy),    32'(m_busy));
      check("m_ack",     32'(dbg_if.dbg_ack),     32'(e_ack));
      check("m_rdata",   32'(dbg_if.dbg_rdata),   32'(m_rdata));
      check("m_err",     32'(dbg_if.dbg_err),     32'(m_err));
      check("m_maxwait", 32'(dbg_if.dbg_maxwait), 32'(m_maxwait));

      if (rst) begin
        m_busy = 0; m_issued = 0; m_rdata = '0; m_err = 0;
        m_maxwait = 0; m_wait = 0;
        if (core_wen) shadow[core_waddr] = core_wdata;
      end else begin
        if (!m_busy) begin
          if (dbg_if.dbg_req) begin
            m_busy = 1; m_issued = 0; m_we = dbg_if.dbg_we;
            m_addr = dbg_if.dbg_addr; m_wdata = dbg_if.dbg_wdata;
            m_wait = 0; m_err = 0;
          end
        end else begin
          if (dbg_if.dbg_req) m_err = 1;
          if (!m_issued) begin
            if (e_issue) begin
              m_issued = 1; m_since = 1;
              if (m_wait > m_maxwait) m_maxwait = m_wait;
              if (!m_we) m_cap = shadow[m_addr];
            end else if (m_wait < 255) begin
              m_wait++;
            end
          end else if (e_ack) begin
            m_busy = 0;
          end else begin
            if (!m_we && m_since == 1) m_rdata = m_cap;
            m_since++;
          end
        end
        if (core_wen) shadow[core_waddr] = core_wdata;
        if (e_issue && m_we) shadow[m_addr] = m_wdata;
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic dbg_issue(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    dbg_if.dbg_req   = 1'b1;
    dbg_if.dbg_we    = we;
    dbg_if.dbg_addr  = a;
    dbg_if.dbg_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ram_clr = 1'b1; cmp_en = 1'b0;
    core_waddr = '0; core_wdata = '0; core_wen = 1'b0;
    core_raddr = '0; core_ren = 1'b0;
    dbg_if.dbg_req = 1'b0; dbg_if.dbg_we = 1'b0;
    dbg_if.dbg_addr = '0; dbg_if.dbg_wdata = '0;

    tick(); tick();
    sample();
    check("rst_busy",    32'(dbg_if.dbg_busy),    32'd0);
    check("rst_ack",     32'(dbg_if.dbg_ack),     32'd0);
    check("rst_rdata",   32'(dbg_if.dbg_rdata),   32'd0);
    check("rst_err",     32'(dbg_if.dbg_err),     32'd0);
    check("rst_maxwait", 32'(dbg_if.dbg_maxwait), 32'd0);

    tick(); rst = 1'b0; ram_clr = 1'b0; cmp_en = 1'b1;

    // Debug write on an idle core: issue at +1, ack at +2.
    tick(); dbg_issue(1'b1, 7'h05, 8'hA5);
    tick(); dbg_if.dbg_req = 1'b0;
    sample();
    check("wr_wen",   32'(wen),   32'd1);
    check("wr_waddr", 32'(waddr), 32'h05);
    check("wr_wdata", 32'(wdata), 32'hA5);
    check("wr_noack", 32'(dbg_if.dbg_ack), 32'd0);
    tick(); sample();
    check("wr_ack",     32'(dbg_if.dbg_ack),     32'd1);
    check("wr_maxwait", 32'(dbg_if.dbg_maxwait), 32'd0);
    tick(); sample();
    check("wr_idle", 32'(dbg_if.dbg_busy), 32'd0);

    // Debug read of the same address: ren at +1, ack with data at +3.
    tick(); dbg_issue(1'b0, 7'h05, 8'h00);
    tick(); dbg_if.dbg_req = 1'b0;
    sample();
    check("rd_ren",   32'(ren),   32'd1);
    check("rd_raddr", 32'(raddr), 32'h05);
    tick(); sample();
    check("rd_noack", 32'(dbg_if.dbg_ack), 32'd0);
    tick(); sample();
    check("rd_ack",   32'(dbg_if.dbg_ack),   32'd1);
    check("rd_rdata", 32'(dbg_if.dbg_rdata), 32'hA5);

    // Core writes a value the next read will fetch.
    tick(); core_wen = 1'b1; core_waddr = 7'h20; core_wdata = 8'h3C;
    tick(); core_wen = 1'b0;

    // Debug read blocked by 10 core reads.
    tick(); dbg_issue(1'b0, 7'h20, 8'h00); core_ren = 1'b1; core_raddr = 7'h10;
    for (int i = 1; i <= 10; i++) begin
      tick(); dbg_if.dbg_req = 1'b0; core_raddr = 7'(7'h10 + i);
      sample();
      check("blk_raddr", 32'(raddr), 32'(7'h10 + i));
    end
    tick(); core_ren = 1'b0;
    sample();
    check("blk_issue", 32'(raddr), 32'h20);
    tick(); tick(); sample();
    check("blk_ack",     32'(dbg_if.dbg_ack),     32'd1);
    check("blk_rdata",   32'(dbg_if.dbg_rdata),   32'h3C);
    check("blk_maxwait", 32'(dbg_if.dbg_maxwait), 32'd10);

    // Second request while busy is dropped and flagged.
    tick(); dbg_issue(1'b1, 7'h30, 8'h77);
    tick(); dbg_issue(1'b1, 7'h31, 8'h11);
    core_wen = 1'b1; core_waddr = 7'h40; core_wdata = 8'h99;
    tick(); dbg_if.dbg_req = 1'b0; core_wen = 1'b0;
    sample();
    check("drop_waddr", 32'(waddr), 32'h30);
    check("drop_wdata", 32'(wdata), 32'h77);
    check("drop_err",   32'(dbg_if.dbg_err), 32'd1);
    tick(); sample();
    check("drop_ack", 32'(dbg_if.dbg_ack), 32'd1);
    tick(); dbg_issue(1'b0, 7'h30, 8'h00);
    tick(); dbg_if.dbg_req = 1'b0;
    sample();
    check("clr_err", 32'(dbg_if.dbg_err), 32'd0);
    tick(); tick(); sample();
    check("raw_rdata", 32'(dbg_if.dbg_rdata), 32'h77);

    // Write blocked for 300 cycles: wait statistic saturates.
    tick(); dbg_issue(1'b1, 7'h50, 8'hC3);
    core_wen = 1'b1; core_waddr = 7'h60; core_wdata = 8'h5A;
    tick(); dbg_if.dbg_req = 1'b0;
    for (int i = 1; i < 300; i++) tick();
    core_wen = 1'b0;
    sample();
    check("sat_waddr", 32'(waddr), 32'h50);
    check("sat_wdata", 32'(wdata), 32'hC3);
    tick(); sample();
    check("sat_ack",     32'(dbg_if.dbg_ack),     32'd1);
    check("sat_maxwait", 32'(dbg_if.dbg_maxwait), 32'd255);

    // Reset while in RCAP: no ack, everything back to reset values.
    tick(); dbg_issue(1'b0, 7'h50, 8'h00);
    tick(); dbg_if.dbg_req = 1'b0;
    tick(); rst = 1'b1;
    sample();
    check("rcap_rst_ack", 32'(dbg_if.dbg_ack), 32'd0);
    tick(); rst = 1'b0;
    sample();
    check("rcap_rst_busy",    32'(dbg_if.dbg_busy),    32'd0);
    check("rcap_rst_ack2",    32'(dbg_if.dbg_ack),     32'd0);
    check("rcap_rst_rdata",   32'(dbg_if.dbg_rdata),   32'd0);
    check("rcap_rst_maxwait", 32'(dbg_if.dbg_maxwait), 32'd0);

    // Reset while in PEND: no debug write, core still passes through.
    tick(); dbg_issue(1'b1, 7'h70, 8'hEE);
    tick(); dbg_if.dbg_req = 1'b0; rst = 1'b1; core_ren = 1'b1; core_raddr = 7'h33;
    sample();
    check("pend_rst_wen",   32'(wen),   32'd0);
    check("pend_rst_ren",   32'(ren),   32'd1);
    check("pend_rst_raddr", 32'(raddr), 32'h33);
    tick(); rst = 1'b0; core_ren = 1'b0;
    sample();
    check("pend_rst_busy", 32'(dbg_if.dbg_busy), 32'd0);
    check("pend_rst_wen2", 32'(wen), 32'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
